// File: rtl/mem_pkg.sv
`default_nettype none
// +--------------------------------------------------------------+
// | mem_pkg : size encodings, FSM state and byte-lane helpers     |
// | Rev 1.0                                                       |
// +--------------------------------------------------------------+
package mem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } state_t;

   function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] lane);
      logic [3:0] be;
      case (size)
         SZ_BYTE: be = 4'b0001 << lane;
         SZ_HALF: be = 4'b0011 << lane;
         SZ_WORD: be = 4'b1111;
         default: be = 4'b0000;
      endcase
      return be;
   endfunction

   // Reserved size 11 is reported as misaligned so it never reaches the RAM.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
      logic bad;
      case (size)
         SZ_BYTE: bad = 1'b0;
         SZ_HALF: bad = lane[0];
         SZ_WORD: bad = (lane != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage
`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
// +--------------------------------------------------------------+
// | load_align : lane select and sign/zero extension of load data |
// | Rev 1.0                                                       |
// +--------------------------------------------------------------+
module load_align
   import mem_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  lane,
   input  logic [1:0]  size,
   input  logic        is_unsigned,
   output logic [31:0] result
);

   logic [7:0]  byte_val;
   logic [15:0] half_val;

   always_comb begin
      byte_val = rdata[8*lane +: 8];
      half_val = lane[1] ? rdata[31:16] : rdata[15:0];
      case (size)
         SZ_BYTE: result = {{24{~is_unsigned & byte_val[7]}}, byte_val};
         SZ_HALF: result = {{16{~is_unsigned & half_val[15]}}, half_val};
         default: result = rdata;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// +--------------------------------------------------------------+
// | mem_access_stage : pipeline memory stage with RAM timeout     |
// | Rev 1.0                                                       |
// +--------------------------------------------------------------+
module mem_access_stage
   import mem_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 16
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_mem_op,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   input  logic [31:0]       req_alu_result,
   input  logic [4:0]        req_rd,
   input  logic              req_reg_write,
   output logic              mem_en,
   output logic [3:0]        mem_we,
   output logic [ADDR_W-3:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ack,
   output logic              wb_valid,
   output logic              data_read,
   output logic [31:0]       data_result,
   output logic [31:0]       alu_result,
   output logic [4:0]        wb_rd,
   output logic              wb_reg_write,
   output logic              misalign_err,
   output logic              bus_err
);

   localparam int CNT_W = $clog2(TIMEOUT);

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic               lat_write;
   logic [1:0]         lat_size;
   logic               lat_unsigned;
   logic [1:0]         lat_lane;
   logic [31:0]        lat_alu;
   logic [4:0]         lat_rd;
   logic               lat_regw;

   logic               accept;
   logic               misal;
   logic [31:0]        rep_wdata;
   logic [31:0]        load_value;

   assign accept = req_valid && req_ready;
   assign misal  = is_misaligned(req_size, req_addr[1:0]);

   always_comb begin
      case (req_size)
         SZ_BYTE: rep_wdata = {4{req_wdata[7:0]}};
         SZ_HALF: rep_wdata = {2{req_wdata[15:0]}};
         default: rep_wdata = req_wdata;
      endcase
   end

   load_align u_load_align (
      .rdata       (mem_rdata),
      .lane        (lat_lane),
      .size        (lat_size),
      .is_unsigned (lat_unsigned),
      .result      (load_value)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         cnt          <= '0;
         req_ready    <= 1'b0;
         mem_en       <= 1'b0;
         mem_we       <= 4'b0000;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         wb_valid     <= 1'b0;
         data_read    <= 1'b0;
         data_result  <= '0;
         alu_result   <= '0;
         wb_rd        <= '0;
         wb_reg_write <= 1'b0;
         misalign_err <= 1'b0;
         bus_err      <= 1'b0;
         lat_write    <= 1'b0;
         lat_size     <= 2'b00;
         lat_unsigned <= 1'b0;
         lat_lane     <= 2'b00;
         lat_alu      <= '0;
         lat_rd       <= '0;
         lat_regw     <= 1'b0;
      end else begin
         wb_valid     <= 1'b0;
         misalign_err <= 1'b0;
         bus_err      <= 1'b0;
         case (state)
            ST_IDLE: begin
               req_ready <= 1'b1;
               if (accept) begin
                  if (!req_mem_op || misal) begin
                     wb_valid     <= 1'b1;
                     data_read    <= 1'b0;
                     alu_result   <= req_alu_result;
                     wb_rd        <= req_rd;
                     wb_reg_write <= req_reg_write && !req_mem_op;
                     misalign_err <= req_mem_op;
                  end else begin
                     state        <= ST_ACCESS;
                     req_ready    <= 1'b0;
                     cnt          <= '0;
                     mem_en       <= 1'b1;
                     mem_addr     <= req_addr[ADDR_W-1:2];
                     mem_we       <= req_write ? byte_enable(req_size, req_addr[1:0]) : 4'b0000;
                     mem_wdata    <= rep_wdata;
                     lat_write    <= req_write;
                     lat_size     <= req_size;
                     lat_unsigned <= req_unsigned;
                     lat_lane     <= req_addr[1:0];
                     lat_alu      <= req_alu_result;
                     lat_rd       <= req_rd;
                     lat_regw     <= req_reg_write;
                  end
               end
            end
            ST_ACCESS: begin
               // An ack arriving on the expiry cycle still completes normally.
               if (mem_ack || cnt == CNT_W'(TIMEOUT - 1)) begin
                  state        <= ST_IDLE;
                  req_ready    <= 1'b1;
                  mem_en       <= 1'b0;
                  mem_we       <= 4'b0000;
                  wb_valid     <= 1'b1;
                  alu_result   <= lat_alu;
                  wb_rd        <= lat_rd;
                  if (mem_ack) begin
                     data_read    <= !lat_write;
                     wb_reg_write <= !lat_write && lat_regw;
                     if (!lat_write)
                        data_result <= load_value;
                  end else begin
                     bus_err      <= 1'b1;
                     data_read    <= 1'b0;
                     wb_reg_write <= 1'b0;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// +--------------------------------------------------------------+
// | tb_mem_access_stage : randomized self-checking bench          |
// | Rev 1.0                                                       |
// +--------------------------------------------------------------+
module tb_mem_access_stage;

   localparam int ADDR_W  = 32;
   localparam int TIMEOUT = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              req_valid;
   logic              req_ready;
   logic              req_mem_op;
   logic              req_write;
   logic [1:0]        req_size;
   logic              req_unsigned;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic [31:0]       req_alu_result;
   logic [4:0]        req_rd;
   logic              req_reg_write;
   logic              mem_en;
   logic [3:0]        mem_we;
   logic [ADDR_W-3:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;
   logic              mem_ack;
   logic              wb_valid;
   logic              data_read;
   logic [31:0]       data_result;
   logic [31:0]       alu_result;
   logic [4:0]        wb_rd;
   logic              wb_reg_write;
   logic              misalign_err;
   logic              bus_err;

   always #5 clk = ~clk;

   mem_access_stage #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_mem_op(req_mem_op),
      .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_alu_result(req_alu_result),
      .req_rd(req_rd), .req_reg_write(req_reg_write),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .wb_valid(wb_valid), .data_read(data_read), .data_result(data_result),
      .alu_result(alu_result), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
      .misalign_err(misalign_err), .bus_err(bus_err)
   );

   int checks   = 0;
   int failures = 0;
   logic [31:0] ram [0:15];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Reference load value: shift the addressed bytes down, mask, then extend.
   function automatic logic [31:0] exp_load(input logic [31:0] word, input int lane,
                                             input int nbytes, input bit uns);
      longint v;
      longint span;
      span = longint'(1) << (8 * nbytes);
      v = (longint'(word) >> (8 * lane)) % span;
      if (!uns && nbytes < 4 && v >= span / 2)
         v = v - span;
      return 32'(v);
   endfunction

   task automatic scramble;
      req_valid      = 1'b0;
      req_mem_op     = 1'($urandom);
      req_write      = 1'($urandom);
      req_size       = 2'($urandom);
      req_unsigned   = 1'($urandom);
      req_addr       = $urandom;
      req_wdata      = $urandom;
      req_alu_result = $urandom;
      req_rd         = 5'($urandom);
      req_reg_write  = 1'($urandom);
   endtask

   task automatic drive(input bit mem_op, input bit wr, input logic [1:0] size, input bit uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] alu, input logic [4:0] rd, input bit regw);
      req_valid      = 1'b1;
      req_mem_op     = mem_op;
      req_write      = wr;
      req_size       = size;
      req_unsigned   = uns;
      req_addr       = addr;
      req_wdata      = wdata;
      req_alu_result = alu;
      req_rd         = rd;
      req_reg_write  = regw;
   endtask

   // ack_at: ACCESS cycle (1..TIMEOUT) on which the RAM acks; 0 means never.
   task automatic run_req(input string tag, input bit mem_op, input bit wr,
                          input logic [1:0] size, input bit uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] alu, input logic [4:0] rd, input bit regw,
                          input int ack_at);
      int          lane, nbytes, idx;
      bit          misal, done;
      logic [31:0] exp_we, exp_wd, exp_data, word;
      lane   = int'(addr % 4);
      idx    = int'((addr / 4) % 16);
      nbytes = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
      misal  = (size == 2'b11) || (lane % nbytes != 0);
      exp_we = wr ? 32'(((1 << nbytes) - 1) << lane) : 32'd0;
      exp_wd = (nbytes == 1) ? (wdata % 256) * 32'h0101_0101 :
               (nbytes == 2) ? (wdata % 65536) * 32'h0001_0001 : wdata;
      word   = ram[idx];
      exp_data = exp_load(word, lane, nbytes, uns);

      chk({tag, ":ready_before"}, req_ready, 1);
      drive(mem_op, wr, size, uns, addr, wdata, alu, rd, regw);
      tick;
      scramble;
      if (!mem_op || misal) begin
         chk({tag, ":wb_valid"}, wb_valid, 1);
         chk({tag, ":misalign_err"}, misalign_err, mem_op);
         chk({tag, ":data_read"}, data_read, 0);
         chk({tag, ":wb_reg_write"}, wb_reg_write, !mem_op && regw);
         chk({tag, ":alu_result"}, alu_result, alu);
         chk({tag, ":wb_rd"}, wb_rd, rd);
         chk({tag, ":mem_en_off"}, mem_en, 0);
      end else begin
         chk({tag, ":mem_en"}, mem_en, 1);
         chk({tag, ":mem_addr"}, mem_addr, addr / 4);
         chk({tag, ":mem_we"}, mem_we, exp_we);
         if (wr) chk({tag, ":mem_wdata"}, mem_wdata, exp_wd);
         chk({tag, ":ready_busy"}, req_ready, 0);
         done = 1'b0;
         for (int k = 1; k <= TIMEOUT && !done; k++) begin
            mem_ack   = (k == ack_at);
            mem_rdata = (k == ack_at) ? word : $urandom;
            tick;
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            if (k == ack_at) begin
               done = 1'b1;
               chk({tag, ":done_wb_valid"}, wb_valid, 1);
               chk({tag, ":done_mem_en"}, mem_en, 0);
               chk({tag, ":done_bus_err"}, bus_err, 0);
               chk({tag, ":done_data_read"}, data_read, !wr);
               chk({tag, ":done_wb_reg_write"}, wb_reg_write, !wr && regw);
               chk({tag, ":done_alu_result"}, alu_result, alu);
               chk({tag, ":done_wb_rd"}, wb_rd, rd);
               if (!wr) chk({tag, ":data_result"}, data_result, exp_data);
               else
                  for (int i = 0; i < 4; i++)
                     if (i >= lane && i < lane + nbytes)
                        ram[idx][8*i +: 8] = 8'(wdata >> (8 * (i - lane)));
            end else if (k == TIMEOUT) begin
               chk({tag, ":to_wb_valid"}, wb_valid, 1);
               chk({tag, ":to_bus_err"}, bus_err, 1);
               chk({tag, ":to_mem_en"}, mem_en, 0);
               chk({tag, ":to_wb_reg_write"}, wb_reg_write, 0);
               chk({tag, ":to_data_read"}, data_read, 0);
               chk({tag, ":to_wb_rd"}, wb_rd, rd);
            end else begin
               chk({tag, ":wait_mem_en"}, mem_en, 1);
               chk({tag, ":wait_mem_we"}, mem_we, exp_we);
               chk({tag, ":wait_wb_valid"}, wb_valid, 0);
            end
         end
      end
      tick;
      chk({tag, ":pulse_wb_valid"}, wb_valid, 0);
      chk({tag, ":pulse_errs"}, {misalign_err, bus_err}, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          op, ack_at;
      logic [1:0]  sz;
      rst_n     = 1'b0;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      drive(0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
      req_valid = 1'b0;
      for (int i = 0; i < 16; i++) ram[i] = $urandom;

      #12;
      chk("reset:req_ready", req_ready, 0);
      chk("reset:wb_valid", wb_valid, 0);
      chk("reset:mem_en", mem_en, 0);
      chk("reset:alu_result", alu_result, 0);
      chk("reset:data_result", data_result, 0);
      rst_n = 1'b1;
      tick;
      chk("post_reset:req_ready", req_ready, 1);

      // Back-to-back pass-through, one per cycle.
      for (int i = 1; i <= 3; i++) begin
         drive(0, 0, 2'b00, 0, 32'h0, 32'h0, i, 5'(i), 1);
         tick;
         chk($sformatf("pass%0d:wb_valid", i), wb_valid, 1);
         chk($sformatf("pass%0d:alu_result", i), alu_result, i);
         chk($sformatf("pass%0d:data_read", i), data_read, 0);
         chk($sformatf("pass%0d:req_ready", i), req_ready, 1);
      end
      scramble;
      tick;
      chk("pass_end:wb_valid", wb_valid, 0);

      ram[0] = 32'h80FF_FF00;
      run_req("sbyte_load", 1, 0, 2'b00, 0, 32'h103, 32'h0, 32'h55, 5'd7, 1, 1);
      run_req("half_store", 1, 1, 2'b01, 0, 32'h6, 32'h0000_ABCD, 32'h66, 5'd8, 1, 1);
      run_req("half_readback", 1, 0, 2'b01, 1, 32'h6, 32'h0, 32'h67, 5'd9, 1, 2);
      run_req("misal_word", 1, 0, 2'b10, 0, 32'h2, 32'h0, 32'h77, 5'd10, 1, 0);
      run_req("timeout", 1, 0, 2'b10, 0, 32'h10, 32'h0, 32'h88, 5'd11, 1, 0);
      run_req("ack_at_expiry", 1, 0, 2'b10, 0, 32'h10, 32'h0, 32'h99, 5'd12, 1, TIMEOUT);

      mem_ack   = 1'b1;
      mem_rdata = $urandom;
      tick;
      mem_ack   = 1'b0;
      chk("idle_ack:wb_valid", wb_valid, 0);
      chk("idle_ack:mem_en", mem_en, 0);

      // Reset in the middle of an access abandons it.
      drive(1, 0, 2'b10, 0, 32'h20, 32'h0, 32'h1, 5'd3, 1);
      tick;
      scramble;
      chk("mid_rst:mem_en_before", mem_en, 1);
      tick;
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst:mem_en", mem_en, 0);
      chk("mid_rst:req_ready", req_ready, 0);
      chk("mid_rst:wb_valid", wb_valid, 0);
      tick;
      chk("mid_rst:wb_valid_hold", wb_valid, 0);
      rst_n = 1'b1;
      tick;
      chk("mid_rst:ready_after", req_ready, 1);
      chk("mid_rst:wb_valid_after", wb_valid, 0);
      run_req("post_rst_load", 1, 0, 2'b00, 1, 32'h21, 32'h0, 32'h2, 5'd4, 1, 1);

      for (int n = 0; n < 40; n++) begin
         op     = $urandom_range(0, 9);
         sz     = 2'($urandom_range(0, 3));
         ack_at = $urandom_range(0, TIMEOUT);
         run_req($sformatf("rand%0d", n), op > 1, 1'($urandom), sz, 1'($urandom),
                 $urandom_range(0, 63), $urandom, $urandom, 5'($urandom), 1'($urandom),
                 ack_at);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
